// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RV = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Store byte enables for a size and byte offset; only called for legal stores.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the addressed byte/halfword down, then extend.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  // Sign extension for B/H, zero extension for BU/HU, W passes through.
  always_comb begin
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time on a req/gnt/rvalid bus, stalls the core.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [31:0]       rs2_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              misaligned_o,
  output logic              err_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  // Counter must reach TIMEOUT_CYCLES without wrapping; abort fires on the
  // TIMEOUT_CYCLES-th busy cycle, or just after if a late gnt moved us on.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              done_q, mis_q, err_q;
  logic [31:0]       ld_q, ld_ext;
  logic [CW-1:0]     cnt_q;

  logic accept, illegal, misal, tmo, gnt_ev, rv_ev, ld_fin, st_fin, abort;

  lsu_load_align u_align (
    .rdata  (data_rdata_i),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_ext)
  );

  // Accept guard (~done_q) keeps the retiring instruction from re-issuing.
  assign accept  = (state_q == IDLE) && lsu_valid_i && !done_q;
  assign illegal = lsu_we_i ? (lsu_funct3_i > F3_W)
                            : (lsu_funct3_i == 3'b011 || lsu_funct3_i[2:1] == 2'b11);
  assign misal   = (lsu_funct3_i[1:0] == 2'b01 && alu_result_i[0]) ||
                   (lsu_funct3_i[1:0] == 2'b10 && alu_result_i[1:0] != 2'b00);
  assign gnt_ev  = (state_q == REQ) && data_gnt_i;
  assign rv_ev   = (state_q == WAIT_RV) && data_rvalid_i;
  assign st_fin  = gnt_ev && we_q;
  assign ld_fin  = !we_q && (rv_ev || (gnt_ev && data_rvalid_i));
  assign tmo     = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && (cnt_q >= TLIM);
  // Bus events in the timeout cycle win over the abort.
  assign abort   = tmo && !gnt_ev && !rv_ev;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !illegal && !misal) state_d = REQ;
      REQ:     if (data_gnt_i)  state_d = (we_q || data_rvalid_i) ? IDLE : WAIT_RV;
               else if (abort)  state_d = IDLE;
      WAIT_RV: if (data_rvalid_i || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; reset drops the request asynchronously via state_q.
  always_comb begin
    data_req_o = (state_q == REQ);
  end

  // Capture the access on accept; bus fields stay stable until retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
    end else if (accept) begin
      addr_q <= alu_result_i;
      we_q   <= lsu_we_i;
      f3_q   <= lsu_funct3_i;
      be_q   <= lsu_we_i ? be_gen(lsu_funct3_i, alu_result_i[1:0]) : 4'b1111;
      case (lsu_funct3_i[1:0])
        2'b00:   wdata_q <= {4{rs2_data_i[7:0]}};
        2'b01:   wdata_q <= {2{rs2_data_i[15:0]}};
        default: wdata_q <= rs2_data_i;
      endcase
    end
  end

  // Completion pulses and held load data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= 32'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      if (accept && illegal) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
        ld_q   <= 32'b0;
      end else if (accept && misal) begin
        done_q <= 1'b1;
        mis_q  <= 1'b1;
      end else if (st_fin) begin
        done_q <= 1'b1;
      end else if (ld_fin) begin
        done_q <= 1'b1;
        ld_q   <= ld_ext;
      end else if (abort) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
        ld_q   <= 32'b0;
      end
    end
  end

  // Busy-cycle counter; keeps counting across REQ->WAIT_RV, clears in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     cnt_q <= '0;
    else if (state_q != IDLE && state_d != IDLE)     cnt_q <= cnt_q + CW'(1);
    else                                             cnt_q <= '0;
  end

  assign stall_o      = lsu_valid_i && !done_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign err_o        = err_q;
  assign load_data_o  = ld_q;
  assign data_we_o    = we_q;
  assign data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a timeline model of each access.
module tb_lsu;

  localparam int T = 4;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        lsu_valid_i = 1'b0, lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'b0;
  logic [31:0] alu_result_i = 32'b0, rs2_data_i = 32'b0;
  logic        stall_o, done_o, misaligned_o, err_o;
  logic [31:0] load_data_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'b0;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i),
    .lsu_funct3_i(lsu_funct3_i), .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
    .misaligned_o(misaligned_o), .err_o(err_o), .data_req_o(data_req_o),
    .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i)
  );

  int    tests = 0, fails = 0;
  logic  chk_en = 1'b0;
  string op_nm = "reset";
  logic        e_req = 1'b0, e_done = 1'b0, e_err = 1'b0, e_mis = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'b0, e_wd = 32'b0, e_ld = 32'b0;
  logic [3:0]  e_be = 4'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s/%s: got %h expected %h", op_nm, nm, act, exp);
    end
  endtask

  // Model: byte enables from size and offset.
  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f, input logic [1:0] a);
    if (!we) return 4'hF;
    if (f == 3'd0) return 4'(1 << a);
    if (f == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f == 3'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a);
    case (f)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(s[15:0]));
      3'd4:    return 32'(s[7:0]);
      3'd5:    return 32'(s[15:0]);
      default: return s;
    endcase
  endfunction

  // Per-cycle comparison of the DUT against the model's expectations.
  always @(negedge clk_i) if (chk_en) begin
    chk("stall", 32'(stall_o), 32'(lsu_valid_i & ~e_done));
    chk("req",   32'(data_req_o), 32'(e_req));
    chk("done",  32'(done_o), 32'(e_done));
    chk("err",   32'(err_o), 32'(e_err));
    chk("mis",   32'(misaligned_o), 32'(e_mis));
    chk("ldata", load_data_o, e_ld);
    if (e_req) begin
      chk("addr", data_addr_o, e_addr);
      chk("be",   32'(data_be_o), 32'(e_be));
      chk("we",   32'(data_we_o), 32'(e_we));
      if (e_we) chk("wdata", data_wdata_o, e_wd);
    end
  end

  // gd: cycles before gnt (-1 never); rd: cycles from gnt to rvalid (-1 never).
  task automatic run_op(input string nm, input logic we, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] rdat);
    bit bad, mis, errx;
    int gb, lim, done_c;
    logic [31:0] ld_new;
    bad = we ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    mis = !bad && ((f[1:0] == 2'd1 && a[0]) || (f[1:0] == 2'd2 && a[1:0] != 2'd0));
    gb = (gd >= 0 && gd + 1 <= T) ? gd + 1 : -1;
    ld_new = e_ld; errx = 1'b0;
    if (bad || mis) begin
      done_c = 1; errx = bad; if (bad) ld_new = 32'b0;
    end else if (gb < 0) begin
      done_c = T + 1; errx = 1'b1; ld_new = 32'b0;
    end else if (we) begin
      done_c = gb + 1;
    end else begin
      lim = (T > gb + 1) ? T : gb + 1;
      if (rd >= 0 && gb + rd <= lim) begin
        done_c = gb + rd + 1; ld_new = m_ld(f, a[1:0], rdat);
      end else begin
        done_c = lim + 1; errx = 1'b1; ld_new = 32'b0;
      end
    end
    op_nm = nm;
    for (int c = 0; c <= done_c; c++) begin
      @(posedge clk_i); #1;
      lsu_valid_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f;
      alu_result_i = a; rs2_data_i = d;
      data_gnt_i    = (c == gb);
      data_rvalid_i = !we && gb >= 0 && rd >= 0 && (c == gb + rd);
      data_rdata_i  = data_rvalid_i ? rdat : $urandom;
      e_req  = !(bad || mis) && c >= 1 && ((gb < 0) ? (c <= T) : (c <= gb));
      e_done = (c == done_c);
      e_err  = e_done && errx;
      e_mis  = e_done && mis;
      if (e_done) e_ld = ld_new;
      e_addr = {a[31:2], 2'b00};
      e_be   = m_be(we, f, a[1:0]);
      e_wd   = m_wd(f, d);
      e_we   = we;
      chk_en = 1'b1;
    end
  endtask

  initial begin
    #2;
    chk("rst_req",   32'(data_req_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_ldata", load_data_o, 32'd0);
    chk("rst_bus",   {data_addr_o[27:0], data_be_o}, 32'd0);
    #15 rst_ni = 1'b1;

    run_op("lw",  1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    chk("lw_lit", load_data_o, 32'hDEADBEEF);
    run_op("lb",  1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80AABBCC);
    chk("lb_lit", load_data_o, 32'hFFFFFF80);
    run_op("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 1, 1, 32'h80AABBCC);
    chk("lbu_lit", load_data_o, 32'h00000080);
    run_op("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 0, 2, 32'h80AABBCC);
    chk("lhu_lit", load_data_o, 32'h000080AA);
    run_op("sh",  1'b1, 3'b001, 32'h306, 32'h1234ABCD, 3, -1, 32'h0);
    chk("sh_hold", load_data_o, 32'h000080AA);
    run_op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    run_op("lh",  1'b0, 3'b001, 32'h002, 32'h0, 2, 0, 32'h80011234);
    chk("lh_lit", load_data_o, 32'hFFFF8001);
    run_op("sb",  1'b1, 3'b000, 32'h002, 32'h00000055, 0, -1, 32'h0);
    run_op("sw",  1'b1, 3'b010, 32'h008, 32'hCAFEF00D, 1, -1, 32'h0);
    run_op("st_ill", 1'b1, 3'b100, 32'h010, 32'h0, 0, -1, 32'h0);
    chk("ill_lit", load_data_o, 32'h0);
    run_op("lw_late", 1'b0, 3'b010, 32'h020, 32'h0, 3, 1, 32'h13572468);
    run_op("lw_tmo",  1'b0, 3'b010, 32'h010, 32'h0, 0, -1, 32'h0);
    chk("tmo_lit", load_data_o, 32'h0);
    run_op("ld_ill",  1'b0, 3'b011, 32'h040, 32'h0, 0, 0, 32'h0);
    run_op("lw_nognt", 1'b0, 3'b010, 32'h050, 32'h0, -1, -1, 32'h0);
    run_op("lh_mis",  1'b0, 3'b001, 32'h001, 32'h0, 0, 0, 32'h0);

    // Reset while waiting for rvalid.
    op_nm = "rst_wait"; chk_en = 1'b0;
    @(posedge clk_i); #1;
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; alu_result_i = 32'h400;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(posedge clk_i); #1; data_gnt_i = 1'b1;
    chk("req_pre", 32'(data_req_o), 32'd1);
    @(posedge clk_i); #1; data_gnt_i = 1'b0;
    rst_ni = 1'b0; #1;
    chk("req", 32'(data_req_o), 32'd0);
    chk("done", 32'(done_o), 32'd0);
    #2 rst_ni = 1'b1;

    // Reset while requesting: the request must drop without a clock edge.
    op_nm = "rst_req";
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("req_pre", 32'(data_req_o), 32'd1);
    #1 rst_ni = 1'b0; #1;
    chk("req", 32'(data_req_o), 32'd0);
    #1 lsu_valid_i = 1'b0;
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      chk("no_done", 32'(done_o), 32'd0);
    end
    e_ld = 32'b0;
    run_op("sw_after_rst", 1'b1, 3'b010, 32'h0, 32'h600DD00D, 0, -1, 32'h0);

    @(posedge clk_i); #1;
    lsu_valid_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    chk_en = 1'b0;
    @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU. Consumes alu_result as the effective address and rs2 data as store data.
- Drives a req/gnt/rvalid data-memory bus.
- Returns sign- or zero-extended load data to write-back.
- Holds the core with stall_o until each access completes, so the single-cycle datapath can tolerate multi-cycle memory.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting in REQ or WAIT_RV before the access is aborted with err_o. 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lsu_valid_i  in  1  the current instruction is a load or store
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_i  in  ADDR_W  effective address
- rs2_data_i  in  32  store data
- stall_o  out  1  holds the PC and register-file write
- done_o  out  1  one-cycle completion pulse
- load_data_o  out  32  extended load data, valid while done_o=1
- misaligned_o  out  1  one-cycle pulse together with done_o
- err_o  out  1  one-cycle pulse together with done_o (illegal funct3 or timeout)
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write enable
- data_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  store data
- data_gnt_i  in  1  request accepted
- data_rvalid_i  in  1  read data valid
- data_rdata_i  in  32  read data

Behaviour:
- Reset (asynchronous, rst_ni=0): state IDLE; all outputs 0; timeout counter 0.
- Reset asserted mid-access abandons the access immediately: data_req_o drops asynchronously and no done_o is produced.
- States:
  - IDLE: waiting for an instruction.
  - REQ: data_req_o=1; addr, we, be and wdata come from registers and stay stable until data_gnt_i.
  - WAIT_RV: load granted, waiting for data_rvalid_i.
- Accept rule: in IDLE with lsu_valid_i=1 and done_o=0, capture address, we, funct3 and data.
  - The done_o=0 guard stops the retiring instruction from being re-accepted.
- Legality checks, made on the accept cycle:
  - Illegal funct3 (store funct3 other than 000/001/010; load funct3 011/110/111): no bus access; next cycle done_o=err_o=1.
  - Misaligned access (H with addr[0]=1, or W with addr[1:0]≠0): no bus access; next cycle done_o=misaligned_o=1.
  - Otherwise go to REQ.
- REQ:
  - On data_gnt_i with a store: go to IDLE; done_o=1 next cycle.
  - On data_gnt_i with a load and data_rvalid_i in the same cycle: complete immediately, same as the WAIT_RV case.
  - On data_gnt_i with a load otherwise: go to WAIT_RV.
- WAIT_RV: on data_rvalid_i, register the extended data, go to IDLE, done_o=1 next cycle.
- rvalid outside WAIT_RV, and outside the REQ-with-gnt case, is ignored.
- Latency: minimum 2 cycles from accept to done_o (gnt and rvalid both in the first REQ cycle).
- stall_o = lsu_valid_i & ~done_o (combinational).
- Store byte lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = halfword replicated x2.
  - SW: be = 4'b1111.
- Loads:
  - data_be_o = 4'b1111.
  - shifted = rdata >> (8*addr[1:0]).
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
- Timeout:
  - The counter increments each cycle spent in REQ or WAIT_RV and clears on leaving either state.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): drop data_req_o, go to IDLE, next cycle done_o=err_o=1, load_data_o=0.
  - A gnt or rvalid arriving in the timeout cycle takes priority over the timeout.
- load_data_o holds its value until the next load completes; it is 0 after reset and after an error.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_e {IDLE, REQ, WAIT_RV}
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - function be_gen(funct3, addr[1:0])
- Sub-module lsu_load_align: combinational shift plus sign/zero extension, taking rdata, addr[1:0] and funct3.

Test Plan:
- LW at 0x100, gnt and rvalid immediate, rdata=0xDEADBEEF -> data_addr_o=0x100, be=1111; done_o at cycle 2; load_data_o=0xDEADBEEF; stall_o=1 for cycles 0–1.
- LB at 0x203, rdata=0x80AABBCC -> load_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x202 -> 0x000080AA.
- SH at 0x306, data 0x1234ABCD, gnt delayed 3 cycles -> data_req_o held 3 cycles with addr=0x304, be=1100, wdata=0xABCDABCD; done_o 1 cycle after gnt.
- LW at 0x101 -> no data_req_o; done_o=misaligned_o=1 on cycle 1.
- Load with gnt but no rvalid, TIMEOUT_CYCLES=4 -> err_o=done_o=1, load_data_o=0, data_req_o low after the timeout.
- rst_ni low while in WAIT_RV -> data_req_o=0 and state IDLE immediately; no done_o; a following SW at 0x0 completes normally.
